pipeline_hazard_ctrl: RTL



---
 rtl/pipeline_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage CPU-211 pipeline.
// Drives hold (Stall1..3) and clear (Flush1..3) controls of the PC-IF, IF-ID
// and ID-EX registers plus the PC write enable. Outputs are Mealy: they follow
// the current state and this cycle's hazard inputs.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall/flush cycle
// counters; without it stall_count/flush_count are tied to zero.
module pipeline_hazard_ctrl #(
  parameter int REG_AW            = 3,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_load,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic              pc_we,
  output logic              Stall1,
  output logic              Stall2,
  output logic              Stall3,
  output logic              Flush1,
  output logic              Flush2,
  output logic              Flush3,
  output logic [15:0]       stall_count,
  output logic [15:0]       flush_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_BR_FLUSH = 2'd2,
    ST_MEM_WAIT = 2'd3
  } state_t;

  localparam logic [2:0] LU_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0] FL_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nxt;
  logic       w_load_use;
  logic       w_run_eval;
  logic       w_pc_we;
  logic       w_stall1, w_stall2, w_stall3;
  logic       w_flush1, w_flush2, w_flush3;

  // Load-use hazard: ID reads the register an in-flight load is about to write.
  assign w_load_use = ex_is_load &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                       (id_uses_rs2 & (id_rs2 == ex_rd)));

  // State and shared bubble/flush down-counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and Mealy control outputs; priority branch > mem_busy > load-use.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_run_eval  = 1'b0;
    w_pc_we     = 1'b1;
    w_stall1    = 1'b0;
    w_stall2    = 1'b0;
    w_stall3    = 1'b0;
    w_flush1    = 1'b0;
    w_flush2    = 1'b0;
    w_flush3    = 1'b0;

    case (r_state)
      ST_RUN: begin
        w_run_eval = 1'b1;
      end
      ST_LU_STALL: begin
        if (branch_taken) begin
          // Redirect wins; leftover bubbles are irrelevant once the front end flushes.
          w_run_eval = 1'b1;
        end else if (mem_busy) begin
          w_run_eval = 1'b1;
        end else begin
          w_stall1 = 1'b1;
          w_stall2 = 1'b1;
          w_flush3 = 1'b1;
          w_pc_we  = 1'b0;
          if (r_cnt == 3'd1) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = 3'd0;
          end else begin
            w_cnt_nxt = r_cnt - 3'd1;
          end
        end
      end
      ST_BR_FLUSH: begin
        if (branch_taken) begin
          w_flush1  = 1'b1;
          w_flush2  = 1'b1;
          w_flush3  = 1'b1;
          w_cnt_nxt = FL_RELOAD;
        end else if (mem_busy) begin
          // Hold the PC while memory stalls, keep squashing; counter frozen.
          w_stall1 = 1'b1;
          w_flush2 = 1'b1;
          w_flush3 = 1'b1;
          w_pc_we  = 1'b0;
        end else begin
          w_flush2 = 1'b1;
          w_flush3 = 1'b1;
          if (r_cnt == 3'd1) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = 3'd0;
          end else begin
            w_cnt_nxt = r_cnt - 3'd1;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (mem_busy) begin
          // EX is frozen, so a pending branch is simply held until memory is ready.
          w_stall1 = 1'b1;
          w_stall2 = 1'b1;
          w_stall3 = 1'b1;
          w_pc_we  = 1'b0;
        end else begin
          w_run_eval = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = 3'd0;
      end
    endcase

    // RUN rules, also used for preemption out of LU_STALL and exit from MEM_WAIT.
    if (w_run_eval) begin
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = 3'd0;
      if (branch_taken) begin
        w_flush1 = 1'b1;
        w_flush2 = 1'b1;
        w_flush3 = 1'b1;
        w_pc_we  = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          w_state_nxt = ST_BR_FLUSH;
          w_cnt_nxt   = FL_RELOAD;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end else if (mem_busy) begin
        w_stall1    = 1'b1;
        w_stall2    = 1'b1;
        w_stall3    = 1'b1;
        w_pc_we     = 1'b0;
        w_state_nxt = ST_MEM_WAIT;
      end else if (w_load_use) begin
        w_stall1 = 1'b1;
        w_stall2 = 1'b1;
        w_flush3 = 1'b1;
        w_pc_we  = 1'b0;
        if (LOAD_STALL_CYCLES > 1) begin
          w_state_nxt = ST_LU_STALL;
          w_cnt_nxt   = LU_RELOAD;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end else begin
        w_state_nxt = ST_RUN;
      end
    end else begin
      w_run_eval = 1'b0;
    end
  end

  // While reset is high every stage is squashed and the PC is held.
  assign pc_we  = ~reset & w_pc_we;
  assign Stall1 = ~reset & w_stall1;
  assign Stall2 = ~reset & w_stall2;
  assign Stall3 = ~reset & w_stall3;
  assign Flush1 = reset | w_flush1;
  assign Flush2 = reset | w_flush2;
  assign Flush3 = reset | w_flush3;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] r_stall_count;
  logic [15:0] r_flush_count;

  // Saturating counts of cycles with the PC-IF register held / IF-ID flushed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_count <= 16'd0;
      r_flush_count <= 16'd0;
    end else begin
      if (Stall1 && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end else begin
        r_stall_count <= r_stall_count;
      end
      if (Flush2 && (r_flush_count != 16'hFFFF)) begin
        r_flush_count <= r_flush_count + 16'd1;
      end else begin
        r_flush_count <= r_flush_count;
      end
    end
  end

  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;
`else
  assign stall_count = 16'd0;
  assign flush_count = 16'd0;
`endif

endmodule
